// File: rtl/alu_seq.sv
// Multi-precision sequencer: feeds a wide operation through the shared 8-bit ALU
// one byte per cycle, LSB first, chaining the registered carry between slices.
module alu_seq #(
  parameter int BYTES = 4,
  parameter int W     = 8*BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   oper,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic [2:0]   alu_oper,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_c_in,
  input  logic [7:0]   alu_sum,
  input  logic         alu_c_out
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]   oper;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          c_out_q, c_out_d;
  logic          ready_q, busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          req_d    = '{oper: oper, a: a, b: b};
          carry_d  = c_in;
          idx_d    = '0;
          result_d = '0;
          c_out_d  = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[8*idx_q +: 8] = alu_sum;
        carry_d                = alu_c_out;
        if (idx_q == LAST) begin
          c_out_d = alu_c_out;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ready_q  <= (state_d == S_IDLE);
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;

  // ALU ports are quiet outside RUN so the shared ALU sees no stray activity.
  assign alu_oper = busy_q ? req_q.oper              : 3'b000;
  assign alu_a    = busy_q ? req_q.a[8*idx_q +: 8]   : 8'h00;
  assign alu_b    = busy_q ? req_q.b[8*idx_q +: 8]   : 8'h00;
  assign alu_c_in = busy_q ? carry_q                 : 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq with a behavioural 8-bit ALU and a
// wide-arithmetic reference model.
module tb_alu_seq;
  localparam int BYTES = 4;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst, start, c_in;
  logic [2:0]   oper;
  logic [W-1:0] a, b;
  logic         ready, busy, done, c_out;
  logic [W-1:0] result;
  logic [2:0]   alu_oper;
  logic [7:0]   alu_a, alu_b, alu_sum;
  logic         alu_c_in, alu_c_out;

  alu_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .oper(oper), .a(a), .b(b), .c_in(c_in),
    .ready(ready), .busy(busy), .done(done), .result(result), .c_out(c_out),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out)
  );

  always #5 clk = ~clk;

  // Team 8-bit ALU, byte-level behaviour.
  logic [8:0] s9;
  always_comb begin
    s9 = '0;
    case (alu_oper)
      3'd0: s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
      3'd1: s9 = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'b0, alu_c_in};
      3'd2: s9 = {1'b0, alu_a & alu_b};
      3'd3: s9 = {1'b0, alu_a | alu_b};
      3'd4: s9 = {1'b0, alu_a ^ alu_b};
      3'd5: s9 = {1'b0, alu_a} + {8'b0, alu_c_in};
      3'd6: s9 = {1'b0, ~alu_a};
      default: s9 = {alu_c_in, alu_b};
    endcase
  end
  assign alu_sum   = s9[7:0];
  assign alu_c_out = s9[8];

  int checks = 0, errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the whole operation over the low n bytes as one wide number.
  function automatic logic [32:0] ref_op(logic [2:0] op, logic [31:0] x, logic [31:0] y,
                                         logic c, int n);
    logic [63:0] m, xm, ym, t;
    m  = (64'd1 << (8*n)) - 64'd1;
    xm = {32'b0, x} & m;
    ym = {32'b0, y} & m;
    case (op)
      3'd0: t = xm + ym + {63'b0, c};
      3'd1: t = xm + (~ym & m) + {63'b0, c};
      3'd2: t = xm & ym;
      3'd3: t = xm | ym;
      3'd4: t = xm ^ ym;
      3'd5: t = xm + {63'b0, c};
      3'd6: t = ~xm & m;
      default: t = ym | ({63'b0, c} << (8*n));
    endcase
    return {t[8*n], t[31:0]};
  endfunction

  function automatic logic carry_into(logic [2:0] op, logic [31:0] x, logic [31:0] y,
                                      logic c, int k);
    logic [32:0] r;
    if (k == 0) return c;
    r = ref_op(op, x, y, c, k);
    return r[32];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'b0, result}, {32'b0, e.res});
        chk("c_out", {63'b0, c_out}, {63'b0, e.co});
      end
    end
  end

  task automatic chk_quiet(string tag);
    chk({tag, "_alu_oper"}, {61'b0, alu_oper}, 64'd0);
    chk({tag, "_alu_a"},    {56'b0, alu_a},    64'd0);
    chk({tag, "_alu_b"},    {56'b0, alu_b},    64'd0);
    chk({tag, "_alu_c_in"}, {63'b0, alu_c_in}, 64'd0);
  endtask

  task automatic run_op(logic [2:0] op, logic [31:0] av, logic [31:0] bv, logic cv,
                        bit protect, bit do_reset);
    int n;
    logic [32:0] r;
    exp_t e;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", {63'b0, ready}, 64'd1);
    start = 1'b1; oper = op; a = av; b = bv; c_in = cv;
    r = ref_op(op, av, bv, cv, BYTES);
    e.res = r[31:0]; e.co = r[32];
    if (!do_reset) sb.push_back(e);
    @(negedge clk);
    for (int k = 0; k < BYTES; k++) begin
      start = protect; a = $urandom; b = $urandom; oper = 3'($urandom); c_in = 1'($urandom);
      chk("run_busy",  {63'b0, busy},  64'd1);
      chk("run_ready", {63'b0, ready}, 64'd0);
      chk("run_done",  {63'b0, done},  64'd0);
      chk("alu_oper", {61'b0, alu_oper}, {61'b0, op});
      chk("alu_a", {56'b0, alu_a}, {56'b0, av[8*k +: 8]});
      chk("alu_b", {56'b0, alu_b}, {56'b0, bv[8*k +: 8]});
      chk("alu_c_in", {63'b0, alu_c_in}, {63'b0, carry_into(op, av, bv, cv, k)});
      if (do_reset && k == 2) begin
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {63'b0, ready}, 64'd1);
        chk("rst_busy",   {63'b0, busy},  64'd0);
        chk("rst_done",   {63'b0, done},  64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_c_out",  {63'b0, c_out}, 64'd0);
        chk_quiet("rst");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("done_pulse", {63'b0, done},  64'd1);
    chk("done_busy",  {63'b0, busy},  64'd0);
    chk("done_ready", {63'b0, ready}, 64'd0);
    chk_quiet("done");
    @(negedge clk);
    start = 1'b0;
    chk("idle_ready", {63'b0, ready}, 64'd1);
    chk("idle_done",  {63'b0, done},  64'd0);
    chk("hold_result", {32'b0, result}, {32'b0, e.res});
    chk_quiet("idle");
    @(negedge clk);
    chk("hold_result2", {32'b0, result}, {32'b0, e.res});
    chk("hold_c_out",   {63'b0, c_out},  {63'b0, e.co});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; oper = '0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {63'b0, ready}, 64'd1);
    chk("reset_busy",   {63'b0, busy},  64'd0);
    chk("reset_done",   {63'b0, done},  64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    chk("reset_c_out",  {63'b0, c_out}, 64'd0);
    chk_quiet("reset");
    // start together with reset: reset wins
    start = 1'b1; a = 32'h1234_5678;
    @(negedge clk);
    chk("rst_start_ready", {63'b0, ready}, 64'd1);
    chk("rst_start_busy",  {63'b0, busy},  64'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op(3'd0, 32'h8000_00FF, 32'h7FFF_FF01, 1'b0, 1'b1, 1'b0);
    run_op(3'd0, 32'h1122_3344, 32'h5566_7788, 1'b1, 1'b0, 1'b1);
    for (int op = 0; op < 8; op++)
      for (int c = 0; c < 2; c++)
        run_op(3'(op), 32'hD2D2_D2D2, 32'hB6B6_B6B6, 1'(c), 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom),
             1'($urandom), (i % 10) == 9);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-precision sequencer for the shared 8-bit ALU. It accepts one wide operation of `BYTES` bytes, latches its operands, and issues it to the ALU one byte per cycle, least significant byte first. The ALU carry-out of each byte is registered and fed back as the carry-in of the next byte. The block sits between a wide-operand requester and the combinational 8-bit ALU, and drives every ALU input port.

## Interface
Parameters:
- `BYTES`, default 4: number of byte slices per operation; must be ≥ 2.
- `W`, default `8*BYTES`: operand and result width. Derived; do not override.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request. Accepted only when `ready`=1.
- `oper`, in, 3: ALU operation code, latched on accept and held for the whole operation.
- `a`, in, W: operand A, latched on accept.
- `b`, in, W: operand B, latched on accept.
- `c_in`, in, 1: initial carry-in, latched on accept.
- `ready`, out, 1: high in IDLE.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `result`, out, W: assembled result. Holds its value until the next accept or reset.
- `c_out`, out, 1: carry-out of the top byte. Holds like `result`.
- `alu_oper`, out, 3: to the ALU `oper` port.
- `alu_a`, out, 8: to the ALU `a` port.
- `alu_b`, out, 8: to the ALU `b` port.
- `alu_c_in`, out, 1: to the ALU `c_in` port.
- `alu_sum`, in, 8: from the ALU `sum` port. Combinational, valid in the same cycle.
- `alu_c_out`, in, 1: from the ALU `c_out` port. Combinational.

## Operation
- States: IDLE, RUN, DONE. Registered state variable, one-hot or binary.
- IDLE, with `start`=1:
  - latch `oper`, `a`, `b`, `c_in` into `op_r`, `a_r`, `b_r`, `carry_r`;
  - set `idx`←0 and clear `result`←0, `c_out`←0;
  - go to RUN.
- IDLE, with `start`=0: stay in IDLE.
- RUN, ALU drive (combinational from registers):
  - `alu_oper`=`op_r`;
  - `alu_a`=`a_r[8*idx +: 8]`;
  - `alu_b`=`b_r[8*idx +: 8]`;
  - `alu_c_in`=`carry_r`.
- RUN, each edge:
  - `result[8*idx +: 8]`←`alu_sum`;
  - `carry_r`←`alu_c_out`;
  - if `idx`==BYTES-1: `c_out`←`alu_c_out`, go to DONE;
  - otherwise `idx`←`idx`+1.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- Carry is chained for every `oper` value. The ALU defines whether a given operation uses its carry.
- `start` is ignored in RUN and DONE. There is no queuing; the requester must wait for `ready`.
- Input changes on `a`, `b`, `oper`, `c_in` after accept have no effect on the operation in flight.
- Outside RUN, all `alu_*` outputs are driven to 0.
- `idx` width is clog2(BYTES); it never wraps past BYTES-1.

## Timing
- Reset values:
  - state=IDLE, `ready`=1, `busy`=0, `done`=0;
  - `result`=0, `c_out`=0;
  - all `alu_*`=0;
  - `idx`=0, `carry_r`=0.
- Reset asserted at any point, including mid-RUN, returns to these values at the next edge. No partial result is kept and no `done` is issued.
- Latency: `start` is sampled at edge E0. RUN covers cycles E0..E0+BYTES-1; byte k is issued in the cycle after edge E0+k.
- `done` is high in the cycle after edge E0+BYTES. `result` and `c_out` are final in that same cycle.
- `ready` returns at edge E0+BYTES+1, so the minimum accept-to-accept spacing is BYTES+2 cycles.
- Throughput: one byte slice per cycle. The ALU path is combinational, so the ALU plus the capture must close in one cycle.
- `start` and `rst` high together: reset wins.

## Test plan
All scenarios use BYTES=4 and the team 8-bit ALU, with add operation `oper`=3'b000 (sum = a+b+c_in).
- Carry chain: `a`=32'h00FF_FFFF, `b`=32'h0000_0001, `c_in`=0 → `result`=32'h0100_0000, `c_out`=0. `done` is pulsed 5 cycles after accept. The `alu_c_in` sequence is 0,1,1,1.
- Top carry: `a`=32'hFFFF_FFFF, `b`=32'h0000_0001 → `result`=32'h0000_0000, `c_out`=1.
- Initial carry-in: `a`=`b`=0, `c_in`=1 → `result`=32'h0000_0001, `c_out`=0. `alu_c_in`=1 only for byte 0.
- Busy protection: second `start` with a different `a` asserted in each RUN cycle and in the DONE cycle → ignored. The first result is unchanged, `ready`=0 throughout, and the next accept happens only after `ready` returns.
- Reset mid-operation: `rst` pulsed while `idx`=2 → next cycle state=IDLE, `ready`=1, `result`=0, `c_out`=0, all `alu_*`=0. No `done` pulse occurs.
- Sweep: all 8 `oper` codes × `c_in` ∈ {0,1}, with `a`=32'hD2D2_D2D2, `b`=32'hB6B6_B6B6 → each `result` byte matches an independently chained byte-wise ALU model.
